spart_stream_driver: RTL and testbench

- Parametrised successor to the SPART echo driver.
- Programs the SPART baud-rate generator from a divisor derived from CLK_HZ and br_cfg. It re-programs automatically whenever br_cfg changes.
- Buffers received bytes in a FIFO and streams them back out through the transmit buffer, with a selectable per-byte transform.
- Sits between the board switches and the SPART register interface. It is the sole bus master on databus.

---
 rtl/spart_pkg.sv | 37 +++
 rtl/sync_fifo.sv | 57 +++++
 rtl/spart_stream_driver.sv | 152 +++++++++++++++
 tb/tb_spart_stream_driver.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spart_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spart_pkg -- FSM states, SPART register map, modes and baud lookup. Rev 1.0
// ---------------------------------------------------------------------------
package spart_pkg;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_CFG_LO  = 3'd1,
    ST_CFG_HI  = 3'd2,
    ST_SERVICE = 3'd3,
    ST_RD      = 3'd4,
    ST_WR      = 3'd5,
    ST_GAP     = 3'd6
  } state_t;

  localparam logic [1:0] ADDR_BUF  = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DIVL = 2'b10;
  localparam logic [1:0] ADDR_DIVH = 2'b11;

  localparam logic [1:0] MODE_ECHO   = 2'b00;
  localparam logic [1:0] MODE_UPPER  = 2'b01;
  localparam logic [1:0] MODE_DROP   = 2'b10;
  localparam logic [1:0] MODE_INVERT = 2'b11;

  function automatic int unsigned baud_of(input logic [1:0] br_cfg);
    case (br_cfg)
      2'b00:   return 4800;
      2'b01:   return 9600;
      2'b10:   return 19200;
      default: return 38400;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync_fifo -- single-clock FIFO with occupancy count and head output. Rev 1.0
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic [DATA_W-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/spart_stream_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spart_stream_driver -- programs the SPART divisor and streams received
// bytes back out through a FIFO with a per-byte transform. Rev 1.0
// ---------------------------------------------------------------------------
module spart_stream_driver
  import spart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       br_cfg,
  input  logic [1:0]       mode,
  input  logic             rda,
  input  logic             tbr,
  output logic             iocs,
  output logic             iorw,
  output logic [1:0]       ioaddr,
  inout  wire  [7:0]       databus,
  output logic             cfg_done,
  output logic [CNT_W-1:0] fifo_count,
  output logic             overflow
);

  function automatic logic [15:0] calc_div(input logic [1:0] sel);
    return 16'(CLK_HZ / (OVERSAMPLE * int'(baud_of(sel))) - 1);
  endfunction

  // Four 16-bit divisors packed low-to-high by br_cfg value.
  localparam logic [63:0] DIV_TABLE = {calc_div(2'd3), calc_div(2'd2),
                                       calc_div(2'd1), calc_div(2'd0)};

  function automatic logic [7:0] xform(input logic [1:0] m, input logic [7:0] b);
    case (m)
      MODE_UPPER:  return (b >= 8'h61 && b <= 8'h7A) ? (b - 8'h20) : b;
      MODE_INVERT: return ~b;
      default:     return b;
    endcase
  endfunction

  state_t     state;
  state_t     next_state;
  logic [1:0] cfg_q;
  logic [7:0] div_lo;
  logic [7:0] div_hi;
  logic       bus_oe;
  logic [7:0] bus_dout;
  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_head;
  logic       rd_keep;

  // Low byte follows the live selection (cfg_q is loaded in the same cycle);
  // the high byte uses the latched copy so both halves always match.
  assign div_lo = DIV_TABLE[{br_cfg, 4'b0000} +: 8];
  assign div_hi = DIV_TABLE[{cfg_q, 4'b1000} +: 8];

  assign databus   = bus_oe ? bus_dout : 8'hzz;
  assign rd_keep   = (state == ST_RD) && (mode != MODE_DROP);
  assign fifo_push = rd_keep && !fifo_full;
  assign fifo_pop  = (state == ST_WR) && !fifo_empty;

  sync_fifo #(
    .DATA_W (8),
    .DEPTH  (FIFO_DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (xform(mode, databus)),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (fifo_head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_INIT;
      cfg_q    <= 2'b00;
      cfg_done <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= next_state;
      if (state == ST_CFG_LO) cfg_q <= br_cfg;
      if (state == ST_CFG_HI)
        cfg_done <= 1'b1;
      else if (state == ST_SERVICE && br_cfg != cfg_q)
        cfg_done <= 1'b0;
      if (rd_keep && fifo_full) overflow <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    iocs       = 1'b0;
    iorw       = 1'b1;
    ioaddr     = ADDR_BUF;
    bus_oe     = 1'b0;
    bus_dout   = 8'h00;
    case (state)
      ST_INIT: next_state = ST_CFG_LO;
      ST_CFG_LO: begin
        iocs       = 1'b1;
        iorw       = 1'b0;
        ioaddr     = ADDR_DIVL;
        bus_oe     = 1'b1;
        bus_dout   = div_lo;
        next_state = ST_CFG_HI;
      end
      ST_CFG_HI: begin
        iocs       = 1'b1;
        iorw       = 1'b0;
        ioaddr     = ADDR_DIVH;
        bus_oe     = 1'b1;
        bus_dout   = div_hi;
        next_state = ST_GAP;
      end
      ST_SERVICE: begin
        if (br_cfg != cfg_q)
          next_state = ST_CFG_LO;
        else if (rda)
          next_state = ST_RD;
        else if (tbr && !fifo_empty)
          next_state = ST_WR;
      end
      ST_RD: begin
        iocs       = 1'b1;
        next_state = ST_GAP;
      end
      ST_WR: begin
        iocs       = 1'b1;
        iorw       = 1'b0;
        bus_oe     = 1'b1;
        bus_dout   = fifo_head;
        next_state = ST_GAP;
      end
      ST_GAP:  next_state = ST_SERVICE;
      default: next_state = ST_INIT;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_spart_stream_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_spart_stream_driver -- SPART bus model plus queue-based reference. Rev 1.0
// ---------------------------------------------------------------------------
module tb_spart_stream_driver;

  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       br_cfg;
  logic [1:0]       mode;
  logic             rda;
  logic             tbr;
  logic             iocs;
  logic             iorw;
  logic [1:0]       ioaddr;
  wire  [7:0]       databus;
  logic             cfg_done;
  logic [CNT_W-1:0] fifo_count;
  logic             overflow;
  logic [7:0]       rx_head;

  always #5 clk = ~clk;

  // SPART side: supplies the receive byte during read cycles only.
  assign databus = (iocs && iorw) ? rx_head : 8'hzz;

  spart_stream_driver #(
    .CLK_HZ     (50000000),
    .OVERSAMPLE (16),
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .br_cfg     (br_cfg),
    .mode       (mode),
    .rda        (rda),
    .tbr        (tbr),
    .iocs       (iocs),
    .iorw       (iorw),
    .ioaddr     (ioaddr),
    .databus    (databus),
    .cfg_done   (cfg_done),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] div_tbl [4] = '{16'd650, 16'd324, 16'd161, 16'd80};

  logic [7:0] rx_q[$];
  logic [7:0] model_q[$];
  logic [7:0] tx_seen[$];
  bit         model_ovf;
  bit         exp_done;
  logic [1:0] model_cfg;
  int         cfg_writes;
  logic [7:0] last_lo, last_hi;
  logic       o_iocs, o_iorw, o_done;
  logic [1:0] o_addr;
  logic [7:0] o_bus;

  typedef struct {
    logic [1:0] m;
    logic [7:0] rx;
    logic [7:0] tx;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_xform(input logic [1:0] m, input logic [7:0] b);
    if (m == 2'b01 && b >= 8'd97 && b <= 8'd122) return b - 8'd32;
    if (m == 2'b11) return 8'd255 - b;
    return b;
  endfunction

  function automatic void clear_model();
    rx_q.delete();
    model_q.delete();
    tx_seen.delete();
    model_ovf = 0;
    exp_done  = 0;
  endfunction

  // One clock: observe at the falling edge, update the SPART model after the rise.
  task automatic tick(input bit kill_on_wr, output bit killed);
    logic [7:0] b;
    bit is_rd, is_wr;
    killed = 0;
    @(negedge clk);
    o_iocs = iocs; o_iorw = iorw; o_addr = ioaddr; o_bus = databus; o_done = cfg_done;
    is_rd = iocs && iorw && (ioaddr == 2'b00);
    is_wr = iocs && !iorw;
    if (is_wr && ioaddr == 2'b10) exp_done = 0;
    check("fifo_count", int'(fifo_count), model_q.size());
    check("overflow", int'(overflow), int'(model_ovf));
    check("cfg_done", int'(cfg_done), int'(exp_done));
    if (is_rd) begin
      b = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
      if (mode != 2'b10) begin
        if (model_q.size() == DEPTH) model_ovf = 1;
        else model_q.push_back(ref_xform(mode, b));
      end
    end
    if (is_wr) begin
      case (ioaddr)
        2'b00: begin
          if (model_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL tx_unexpected: got 0x%0h expected no write", databus);
          end else begin
            b = model_q.pop_front();
            check("tx_byte", int'(databus), int'(b));
            tx_seen.push_back(databus);
          end
        end
        2'b10: begin
          b = div_tbl[br_cfg][7:0];
          check("div_lo", int'(databus), int'(b));
          model_cfg = br_cfg; last_lo = databus; cfg_writes++;
        end
        2'b11: begin
          b = div_tbl[model_cfg][15:8];
          check("div_hi", int'(databus), int'(b));
          exp_done = 1; last_hi = databus; cfg_writes++;
        end
        default: begin
          checks++; errors++;
          $display("FAIL bad_addr: got write to %0d expected none", ioaddr);
        end
      endcase
      if (ioaddr == 2'b00 && kill_on_wr) begin
        #1 rst_n = 1'b0;
        #1;
        check("rst_iocs", int'(iocs), 0);
        check("rst_count", int'(fifo_count), 0);
        check("rst_ovf", int'(overflow), 0);
        clear_model();
        rx_head = 8'h00;
        rda = 1'b0;
        killed = 1;
        return;
      end
    end
    @(posedge clk);
    #1;
    rda = (rx_q.size() != 0);
    rx_head = rda ? rx_q[0] : 8'h00;
  endtask

  task automatic release_and_configure();
    bit k;
    logic [7:0] lo, hi;
    lo = div_tbl[br_cfg][7:0];
    hi = div_tbl[br_cfg][15:8];
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_iocs", int'(iocs), 0);
    check("reset_iorw", int'(iorw), 1);
    check("reset_ioaddr", int'(ioaddr), 0);
    check("reset_cfg_done", int'(cfg_done), 0);
    check("reset_count", int'(fifo_count), 0);
    check("reset_ovf", int'(overflow), 0);
    tick(0, k);
    check("init_idle", int'(o_iocs), 0);
    tick(0, k);
    check("cfglo_addr", int'({o_iocs, o_iorw, o_addr}), int'({1'b1, 1'b0, 2'b10}));
    check("cfglo_data", int'(o_bus), int'(lo));
    tick(0, k);
    check("cfghi_addr", int'({o_iocs, o_iorw, o_addr}), int'({1'b1, 1'b0, 2'b11}));
    check("cfghi_data", int'(o_bus), int'(hi));
    tick(0, k);
    check("cfg_done_set", int'(o_done), 1);
    check("gap_idle", int'(o_iocs), 0);
  endtask

  task automatic drain();
    bit k;
    int n;
    tbr = 1'b1;
    n = 0;
    while ((model_q.size() != 0 || rx_q.size() != 0) && n < 300) begin
      tick(0, k);
      n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d queued expected 0", model_q.size());
    end
    repeat (4) tick(0, k);
  endtask

  initial begin
    bit k;
    int n, cw;
    logic [7:0] sent[$];
    logic [7:0] b;

    vecs = '{'{2'b00, 8'h41, 8'h41}, '{2'b01, 8'h61, 8'h41}, '{2'b01, 8'h7A, 8'h5A},
             '{2'b01, 8'h5B, 8'h5B}, '{2'b11, 8'h0F, 8'hF0}, '{2'b01, 8'h60, 8'h60},
             '{2'b01, 8'h7B, 8'h7B}, '{2'b00, 8'hFF, 8'hFF}, '{2'b11, 8'h00, 8'hFF},
             '{2'b01, 8'h41, 8'h41}};
    rst_n = 1'b1; br_cfg = 2'b01; mode = 2'b00; rda = 1'b0; tbr = 1'b0; rx_head = 8'h00;
    cfg_writes = 0; model_cfg = 2'b00; last_lo = 8'h00; last_hi = 8'h00;
    clear_model();
    #2 rst_n = 1'b0;
    release_and_configure();

    // Table-driven single-byte round trips.
    tbr = 1'b1;
    foreach (vecs[i]) begin
      mode = vecs[i].m;
      tx_seen.delete();
      rx_q.push_back(vecs[i].rx);
      n = 0;
      while (tx_seen.size() == 0 && n < 20) begin tick(0, k); n++; end
      if (tx_seen.size() == 0) begin
        checks++; errors++;
        $display("FAIL vec%0d_timeout: got no write expected 0x%0h", i, vecs[i].tx);
      end else check($sformatf("vec%0d_tx", i), int'(tx_seen[0]), int'(vecs[i].tx));
    end

    // Receive-only mode must not queue anything.
    mode = 2'b10;
    tx_seen.delete();
    rx_q.push_back(8'h33);
    repeat (10) tick(0, k);
    check("drop_no_tx", tx_seen.size(), 0);
    check("drop_count", int'(fifo_count), 0);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 2) == 0) rx_q.push_back(8'($urandom));
      if ($urandom_range(0, 9) == 0) mode = 2'($urandom);
      tbr = 1'($urandom);
      if (exp_done && $urandom_range(0, 30) == 0) br_cfg = 2'($urandom);
      tick(0, k);
    end
    drain();

    // Overflow: nine bytes into an eight-entry buffer with transmit blocked.
    mode = 2'b00; tbr = 1'b0; tx_seen.delete(); sent.delete();
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      sent.push_back(b);
      rx_q.push_back(b);
    end
    n = 0;
    while (rx_q.size() != 0 && n < 100) begin tick(0, k); n++; end
    repeat (3) tick(0, k);
    check("ovf_count", int'(fifo_count), 8);
    check("ovf_flag", int'(overflow), 1);
    drain();
    check("ovf_tx_len", tx_seen.size(), 8);
    for (int i = 0; i < 8 && i < tx_seen.size(); i++)
      check($sformatf("ovf_tx%0d", i), int'(tx_seen[i]), int'(sent[i]));
    check("ovf_sticky", int'(overflow), 1);

    // Reconfiguration with bytes queued.
    br_cfg = 2'b01;
    repeat (12) tick(0, k);
    tbr = 1'b0; tx_seen.delete();
    for (int i = 0; i < 3; i++) rx_q.push_back(8'h10 + 8'(i));
    n = 0;
    while (rx_q.size() != 0 && n < 50) begin tick(0, k); n++; end
    repeat (3) tick(0, k);
    check("pre_reconf_count", int'(fifo_count), 3);
    br_cfg = 2'b11;
    cw = cfg_writes;
    n = 0;
    while (!(exp_done && cfg_writes == cw + 2) && n < 20) begin tick(0, k); n++; end
    check("reconf_writes", cfg_writes - cw, 2);
    check("reconf_lo", int'(last_lo), 8'h50);
    check("reconf_hi", int'(last_hi), 8'h00);
    check("reconf_count", int'(fifo_count), 3);
    drain();
    check("reconf_tx_len", tx_seen.size(), 3);

    // Reset in the middle of a write cycle.
    tbr = 1'b0;
    rx_q.push_back(8'hA1);
    rx_q.push_back(8'hA2);
    repeat (12) tick(0, k);
    tbr = 1'b1;
    n = 0;
    k = 0;
    while (!k && n < 30) begin tick(1, k); n++; end
    if (!k) begin
      checks++; errors++;
      $display("FAIL wr_reset_timeout: got no write cycle expected one");
      rst_n = 1'b0;
      clear_model();
    end
    tbr = 1'b0;
    release_and_configure();
    repeat (4) tick(0, k);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
